// File: rtl/seq_pattern_tx.sv
// Serial pattern source: streams 1001 (sel=0) or 010 (sel=1) MSB first, N times, with optional idle gaps.
// First bit one cycle after accept; no backpressure, start is only taken while ready=1 and abort cancels.
module seq_pattern_tx #(
  parameter int   RPT_W      = 4,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sel,
  input  logic [RPT_W-1:0] rpt_cnt,
  input  logic             abort,
  output logic             ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_t           state, state_n;
  logic             sel_q, sel_n;
  logic [RPT_W-1:0] rpt_left, rpt_n;
  logic [1:0]       bit_idx, idx_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             last_bit;

  function automatic logic pat_bit(input logic s, input logic [1:0] idx);
    if (s) return (idx == 2'd1);
    return (idx == 2'd0) || (idx == 2'd3);
  endfunction

  assign last_bit = (bit_idx == (sel_q ? 2'd2 : 2'd3));

  // rpt_left counts repetitions still owed, including the one in flight.
  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    rpt_n   = rpt_left;
    idx_n   = bit_idx;
    gap_n   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          sel_n   = sel;
          rpt_n   = (rpt_cnt == '0) ? RPT_W'(1) : rpt_cnt;
          idx_n   = 2'd0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_n = S_IDLE;
          idx_n   = 2'd0;
        end else if (last_bit) begin
          if (rpt_left > RPT_W'(1)) begin
            rpt_n = rpt_left - RPT_W'(1);
            idx_n = 2'd0;
            if (GAP_CYCLES > 0) begin
              state_n = S_GAP;
              gap_n   = GAP_LAST;
            end else begin
              state_n = S_SHIFT;
            end
          end else begin
            state_n = S_DONE;
          end
        end else begin
          idx_n = bit_idx + 2'd1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (gap_cnt == '0) begin
          state_n = S_SHIFT;
          idx_n   = 2'd0;
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      sel_q    <= 1'b0;
      rpt_left <= '0;
      bit_idx  <= 2'd0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      sel_q    <= sel_n;
      rpt_left <= rpt_n;
      bit_idx  <= idx_n;
      gap_cnt  <= gap_n;
    end
  end

  // Outputs are registered copies of what the next state will present.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready   <= 1'b1;
      x_out   <= IDLE_LEVEL;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      ready   <= (state_n == S_IDLE);
      x_valid <= (state_n == S_SHIFT);
      x_out   <= (state_n == S_SHIFT) ? pat_bit(sel_n, idx_n) : IDLE_LEVEL;
      busy    <= (state_n == S_SHIFT) || (state_n == S_GAP);
      done    <= (state_n == S_DONE);
    end
  end

endmodule
